aux_cmd_sequencer: RTL

Per-stream auxiliary command sequencer that reads MOSI command words out of port B of the 16-bank dual-port command RAM and delivers one 16-bit command per SPI frame to the RHD2000 SPI engine. On each frame strobe it reads the current index from the selected bank, presents the word with a one-cycle valid, and advances the index, looping from a programmable end index back to a programmable loop index. It sits between the command RAM bank (read-only port B) and the MOSI shift logic.

---
 rtl/aux_cmd_sequencer_pkg.sv | 15 +
 rtl/aux_cmd_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/aux_cmd_sequencer_pkg.sv
// Shared types and constants for the auxiliary command sequencer.
package aux_cmd_sequencer_pkg;

  localparam int unsigned AUX_ADDR_W     = 10;
  localparam int unsigned AUX_BANK_W     = 4;
  localparam int unsigned AUX_RAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } aux_seq_state_t;

endpackage

// File: rtl/aux_cmd_sequencer.sv
// Reads one MOSI command per SPI frame from a command RAM bank, looping max_index -> loop_index.
// Optional feature: AUX_CMD_ONESHOT_EN adds oneshot/seq_done (stop and hold at max_index).
module aux_cmd_sequencer
  import aux_cmd_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = AUX_ADDR_W,
  parameter int unsigned BANK_W = AUX_BANK_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              frame_start,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic [ADDR_W-1:0] max_index,
  input  logic [ADDR_W-1:0] loop_index,
  output logic [BANK_W-1:0] RAM_bank_sel_B,
  output logic [ADDR_W-1:0] RAM_addr_B,
  input  logic [15:0]       RAM_data_out_B,
  output logic [15:0]       cmd_out,
  output logic              cmd_valid,
  output logic [ADDR_W-1:0] cmd_index,
`ifdef AUX_CMD_ONESHOT_EN
  input  logic              oneshot,
  output logic              seq_done,
`endif
  output logic              overrun
);

  aux_seq_state_t r_state, w_state_next;

  logic [ADDR_W-1:0] r_index, w_index_next;
  logic [BANK_W-1:0] r_bank_q, w_bank_q_next;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_next;
  logic [BANK_W-1:0] r_ram_bank, w_ram_bank_next;
  logic [15:0]       r_cmd_out, w_cmd_out_next;
  logic              r_cmd_valid, w_cmd_valid_next;
  logic [ADDR_W-1:0] r_cmd_index, w_cmd_index_next;
  logic              r_overrun, w_overrun_next;
  logic              w_at_end;
`ifdef AUX_CMD_ONESHOT_EN
  logic              r_seq_done, w_seq_done_next;
`endif

  // >= rather than == so a max_index lowered below the live index still wraps
  assign w_at_end = (r_index >= max_index);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (run && frame_start) w_state_next = ST_ADDR;
      ST_ADDR:    w_state_next = ST_WAIT;
      ST_WAIT:    w_state_next = ST_CAPTURE;
      ST_CAPTURE: w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_index_next     = r_index;
    w_bank_q_next    = r_bank_q;
    w_ram_addr_next  = r_ram_addr;
    w_ram_bank_next  = r_ram_bank;
    w_cmd_out_next   = r_cmd_out;
    w_cmd_index_next = r_cmd_index;
    w_cmd_valid_next = 1'b0;
    w_overrun_next   = r_overrun | (frame_start && (r_state != ST_IDLE));
`ifdef AUX_CMD_ONESHOT_EN
    w_seq_done_next  = run ? r_seq_done : 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!run) begin
          w_index_next  = '0;
          w_bank_q_next = bank_sel;
        end
      end
      ST_ADDR: begin
        w_ram_addr_next = r_index;
        w_ram_bank_next = r_bank_q;
      end
      ST_CAPTURE: begin
        w_cmd_out_next   = RAM_data_out_B;
        w_cmd_index_next = r_index;
        w_cmd_valid_next = 1'b1;
        if (w_at_end) begin
`ifdef AUX_CMD_ONESHOT_EN
          if (oneshot) begin
            w_index_next    = max_index;
            w_seq_done_next = 1'b1;
          end else begin
            w_index_next  = loop_index;
            w_bank_q_next = bank_sel;
          end
`else
          w_index_next  = loop_index;
          w_bank_q_next = bank_sel;
`endif
        end else begin
          w_index_next = r_index + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_index     <= '0;
      r_bank_q    <= '0;
      r_ram_addr  <= '0;
      r_ram_bank  <= '0;
      r_cmd_out   <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_index <= '0;
      r_overrun   <= 1'b0;
`ifdef AUX_CMD_ONESHOT_EN
      r_seq_done  <= 1'b0;
`endif
    end else begin
      r_index     <= w_index_next;
      r_bank_q    <= w_bank_q_next;
      r_ram_addr  <= w_ram_addr_next;
      r_ram_bank  <= w_ram_bank_next;
      r_cmd_out   <= w_cmd_out_next;
      r_cmd_valid <= w_cmd_valid_next;
      r_cmd_index <= w_cmd_index_next;
      r_overrun   <= w_overrun_next;
`ifdef AUX_CMD_ONESHOT_EN
      r_seq_done  <= w_seq_done_next;
`endif
    end
  end

  assign RAM_addr_B     = r_ram_addr;
  assign RAM_bank_sel_B = r_ram_bank;
  assign cmd_out        = r_cmd_out;
  assign cmd_valid      = r_cmd_valid;
  assign cmd_index      = r_cmd_index;
  assign overrun        = r_overrun;
`ifdef AUX_CMD_ONESHOT_EN
  assign seq_done       = r_seq_done;
`endif

endmodule
